// File: rtl/debug_run_control.sv
// Run-control and state-dump unit: byte-stream commands drive the pipeline enable for
// free-run or N-cycle stepping, and after a stop the PC, cycle count and register file go out as bytes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a command byte
// GET_LO   | waiting for the low byte of the step count
// GET_HI   | waiting for the high byte of the step count
// RUN      | pipeline enabled until HALT reaches WB
// STEP     | pipeline enabled for the remaining step count
// DUMP_PC  | snapshot PC/counter, stream PC bytes
// DUMP_CYC | stream cycle counter bytes
// DUMP_REG | stream register file, one register per word
module debug_run_control #(
    parameter int LEN                  = 32,
    parameter int CANTIDAD_REGISTROS   = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CYCLES            = 32,
    parameter int NB_STEP              = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [7:0]                      i_rx_data,
    input  logic                            i_rx_valid,
    output logic                            o_rx_ready,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready,
    output logic                            o_pipe_enable,
    input  logic                            i_halt,
    input  logic [LEN-1:0]                  i_pc,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_reg_addr,
    input  logic [LEN-1:0]                  i_reg_data,
    output logic                            o_halted,
    output logic                            o_busy
);

    localparam int NB_IDX = 8;
    localparam logic [NB_IDX-1:0] LAST_WORD_BYTE = NB_IDX'(LEN / 8 - 1);
    localparam logic [NB_IDX-1:0] LAST_CYC_BYTE  = NB_IDX'(NB_CYCLES / 8 - 1);
    localparam logic [NB_ADDRESS_REGISTROS-1:0] LAST_REG =
        NB_ADDRESS_REGISTROS'(CANTIDAD_REGISTROS - 1);

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        GET_LO,
        GET_HI,
        RUN,
        STEP,
        DUMP_PC,
        DUMP_CYC,
        DUMP_REG
    } state_t;

    state_t                          state;
    logic                            rx_ready;
    logic                            tx_valid;
    logic [7:0]                      tx_data;
    logic                            pipe_enable;
    logic                            halted;
    logic [7:0]                      step_lo;
    logic [NB_STEP-1:0]              step_cnt;
    logic [NB_CYCLES-1:0]            cycle_cnt;
    logic [NB_CYCLES-1:0]            cyc_snap;
    logic [LEN-1:0]                  pc_snap;
    logic [NB_IDX-1:0]               byte_idx;
    logic [NB_ADDRESS_REGISTROS-1:0] reg_idx;

    logic                            rx_fire;
    logic                            tx_fire;
    logic [NB_IDX-1:0]               byte_next;
    logic [NB_STEP-1:0]              step_count_rx;

    assign rx_fire       = i_rx_valid & rx_ready;
    assign tx_fire       = tx_valid & i_tx_ready;
    assign byte_next     = byte_idx + NB_IDX'(1);
    assign step_count_rx = {i_rx_data, step_lo};

    function automatic logic [7:0] word_byte(input logic [LEN-1:0] w, input logic [NB_IDX-1:0] idx);
        logic [LEN-1:0] s;
        s = w >> {idx, 3'b000};
        return s[7:0];
    endfunction

    function automatic logic [7:0] cyc_byte(input logic [NB_CYCLES-1:0] w, input logic [NB_IDX-1:0] idx);
        logic [NB_CYCLES-1:0] s;
        s = w >> {idx, 3'b000};
        return s[7:0];
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_cnt <= '0;
        end else if (pipe_enable && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + NB_CYCLES'(1);
        end
    end

    // rx_ready is a register rather than a decode of state so it reads 0 while reset is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            pipe_enable <= 1'b0;
            halted      <= 1'b0;
            step_lo     <= '0;
            step_cnt    <= '0;
            cyc_snap    <= '0;
            pc_snap     <= '0;
            byte_idx    <= '0;
            reg_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        if (i_rx_data == CMD_RUN && !halted) begin
                            state       <= RUN;
                            pipe_enable <= 1'b1;
                            rx_ready    <= 1'b0;
                        end else if (i_rx_data == CMD_STEP) begin
                            state <= GET_LO;
                        end else if (i_rx_data == CMD_DUMP) begin
                            state    <= DUMP_PC;
                            rx_ready <= 1'b0;
                        end
                    end
                end

                GET_LO: begin
                    if (rx_fire) begin
                        step_lo <= i_rx_data;
                        state   <= GET_HI;
                    end
                end

                GET_HI: begin
                    if (rx_fire) begin
                        rx_ready <= 1'b0;
                        if (halted || step_count_rx == '0) begin
                            state <= DUMP_PC;
                        end else begin
                            state       <= STEP;
                            step_cnt    <= step_count_rx;
                            pipe_enable <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (i_halt) begin
                        halted      <= 1'b1;
                        pipe_enable <= 1'b0;
                        state       <= DUMP_PC;
                    end
                end

                STEP: begin
                    step_cnt <= step_cnt - NB_STEP'(1);
                    if (i_halt) begin
                        halted      <= 1'b1;
                        pipe_enable <= 1'b0;
                        state       <= DUMP_PC;
                    end else if (step_cnt == NB_STEP'(1)) begin
                        pipe_enable <= 1'b0;
                        state       <= DUMP_PC;
                    end
                end

                DUMP_PC: begin
                    // First cycle here: the counter already includes the last enabled cycle.
                    if (!tx_valid) begin
                        pc_snap  <= i_pc;
                        cyc_snap <= cycle_cnt;
                        tx_data  <= i_pc[7:0];
                        tx_valid <= 1'b1;
                        byte_idx <= '0;
                    end else if (tx_fire) begin
                        if (byte_idx == LAST_WORD_BYTE) begin
                            state    <= DUMP_CYC;
                            byte_idx <= '0;
                            tx_data  <= cyc_snap[7:0];
                        end else begin
                            byte_idx <= byte_next;
                            tx_data  <= word_byte(pc_snap, byte_next);
                        end
                    end
                end

                DUMP_CYC: begin
                    if (tx_fire) begin
                        if (byte_idx == LAST_CYC_BYTE) begin
                            state    <= DUMP_REG;
                            byte_idx <= '0;
                            reg_idx  <= '0;
                            tx_valid <= 1'b0;
                        end else begin
                            byte_idx <= byte_next;
                            tx_data  <= cyc_byte(cyc_snap, byte_next);
                        end
                    end
                end

                DUMP_REG: begin
                    // One idle cycle per register lets the regfile read settle on the new address.
                    if (!tx_valid) begin
                        tx_data  <= word_byte(i_reg_data, byte_idx);
                        tx_valid <= 1'b1;
                    end else if (tx_fire) begin
                        if (byte_idx != LAST_WORD_BYTE) begin
                            byte_idx <= byte_next;
                            tx_data  <= word_byte(i_reg_data, byte_next);
                        end else begin
                            byte_idx <= '0;
                            tx_valid <= 1'b0;
                            if (reg_idx == LAST_REG) begin
                                reg_idx  <= '0;
                                state    <= IDLE;
                                rx_ready <= 1'b1;
                            end else begin
                                reg_idx <= reg_idx + NB_ADDRESS_REGISTROS'(1);
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_rx_ready    = rx_ready;
    assign o_tx_data     = tx_data;
    assign o_tx_valid    = tx_valid;
    assign o_pipe_enable = pipe_enable;
    assign o_halted      = halted;
    assign o_busy        = (state != IDLE);
    assign o_reg_addr    = (state == DUMP_REG) ? reg_idx : '0;

endmodule

// File: tb/tb_debug_run_control.sv
// Bench for debug_run_control: command sequences against a queue of expected dump bytes
// built from a PC value, a cycle-count model and a fixed register-file pattern.
module tb_debug_run_control;

    localparam int LEN     = 32;
    localparam int NREG    = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_CYC  = 32;
    localparam int DUMP_BYTES = LEN / 8 + NB_CYC / 8 + NREG * (LEN / 8);

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [7:0]         i_rx_data = '0;
    logic               i_rx_valid = 1'b0;
    logic               o_rx_ready;
    logic [7:0]         o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready = 1'b1;
    logic               o_pipe_enable;
    logic               i_halt = 1'b0;
    logic [LEN-1:0]     i_pc = '0;
    logic [NB_ADDR-1:0] o_reg_addr;
    logic [LEN-1:0]     i_reg_data;
    logic               o_halted;
    logic               o_busy;

    typedef struct {
        logic [7:0]         data;
        logic [NB_ADDR-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   en_cnt       = 0;
    int   halt_at      = 0;
    int   dump_cnt     = 0;

    always #5 i_clk = ~i_clk;

    debug_run_control #(
        .LEN(LEN),
        .CANTIDAD_REGISTROS(NREG),
        .NB_ADDRESS_REGISTROS(NB_ADDR),
        .NB_CYCLES(NB_CYC),
        .NB_STEP(16)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid),
        .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready),
        .o_pipe_enable(o_pipe_enable),
        .i_halt(i_halt),
        .i_pc(i_pc),
        .o_reg_addr(o_reg_addr),
        .i_reg_data(i_reg_data),
        .o_halted(o_halted),
        .o_busy(o_busy)
    );

    function automatic logic [LEN-1:0] reg_val(input logic [NB_ADDR-1:0] a);
        return 32'h1000_0000 + LEN'(a) * 32'h0102_0304;
    endfunction

    assign i_reg_data = reg_val(o_reg_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_dump(input logic [LEN-1:0] pc, input logic [NB_CYC-1:0] cyc);
        for (int i = 0; i < LEN / 8; i++)
            exp_q.push_back('{data: 8'(pc >> (8 * i)), addr: '0});
        for (int i = 0; i < NB_CYC / 8; i++)
            exp_q.push_back('{data: 8'(cyc >> (8 * i)), addr: '0});
        for (int r = 0; r < NREG; r++)
            for (int b = 0; b < LEN / 8; b++)
                exp_q.push_back('{data: 8'(reg_val(NB_ADDR'(r)) >> (8 * b)), addr: NB_ADDR'(r)});
    endtask

    // Counts enabled cycles, injects HALT on a chosen enabled cycle, and scores dump bytes.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            i_halt = 1'b0;
        end else begin
            if (o_pipe_enable) begin
                en_cnt++;
                i_halt = (halt_at != 0) && (en_cnt == halt_at);
            end else begin
                i_halt = 1'b0;
            end
            if (o_tx_valid && i_tx_ready) begin
                dump_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("tx_byte", 32'(o_tx_data), 32'(e.data));
                    check_val("reg_addr", 32'(o_reg_addr), 32'(e.addr));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            if (o_rx_ready) break;
            n++;
            if (n > 50) begin
                check_val("rx_accept", 32'(o_rx_ready), 32'd1);
                break;
            end
        end
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
    endtask

    task automatic wait_dump();
        int   n = 0;
        logic done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge i_clk);
            n++;
            done = (exp_q.size() == 0) && !o_busy;
        end
        check_val("dump_done", 32'(done), 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_count(input int at);
        int n = 0;
        while (dump_cnt < at && n < 2000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        logic [7:0] d0;
        logic       v0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_val("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_val("rst_tx_data", 32'(o_tx_data), 32'd0);
        check_val("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        check_val("rst_pipe_en", 32'(o_pipe_enable), 32'd0);
        check_val("rst_halted", 32'(o_halted), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_reg_addr", 32'(o_reg_addr), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_val("idle_rx_ready", 32'(o_rx_ready), 32'd1);
        check_val("idle_busy", 32'(o_busy), 32'd0);

        // STEP 3: counter model 0 -> 3
        @(posedge i_clk);
        #1 i_pc = 32'h0040_0010;
        push_dump(i_pc, 32'd3);
        en_cnt = 0;
        dump_cnt = 0;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h00);
        wait_dump();
        check_val("step3_enables", 32'(en_cnt), 32'd3);
        check_val("step3_bytes", 32'(dump_cnt), 32'(DUMP_BYTES));

        // STEP 0: no enabled cycles, counter stays 3
        i_pc = 32'h0040_0020;
        push_dump(i_pc, 32'd3);
        en_cnt = 0;
        dump_cnt = 0;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_dump();
        check_val("step0_enables", 32'(en_cnt), 32'd0);
        check_val("step0_bytes", 32'(dump_cnt), 32'(DUMP_BYTES));

        send_byte(8'h7F);
        repeat (3) @(negedge i_clk);
        check_val("unk_busy", 32'(o_busy), 32'd0);
        check_val("unk_rx_ready", 32'(o_rx_ready), 32'd1);
        check_val("unk_pipe_en", 32'(o_pipe_enable), 32'd0);
        check_val("unk_tx_valid", 32'(o_tx_valid), 32'd0);

        // RUN with HALT on the 10th enabled cycle after a fresh reset
        do_reset();
        check_val("reset_halted", 32'(o_halted), 32'd0);
        @(posedge i_clk);
        #1 i_pc = 32'h0040_0100;
        push_dump(i_pc, 32'd10);
        halt_at = 10;
        en_cnt = 0;
        dump_cnt = 0;
        send_byte(8'h01);
        wait_dump();
        halt_at = 0;
        check_val("run_enables", 32'(en_cnt), 32'd10);
        check_val("run_halted", 32'(o_halted), 32'd1);
        check_val("run_bytes", 32'(dump_cnt), 32'(DUMP_BYTES));

        send_byte(8'h01);
        repeat (3) @(negedge i_clk);
        check_val("rerun_busy", 32'(o_busy), 32'd0);
        check_val("rerun_pipe_en", 32'(o_pipe_enable), 32'd0);
        check_val("rerun_enables", 32'(en_cnt), 32'd10);

        // DUMP with 5 cycles of backpressure in the register section
        @(posedge i_clk);
        #1 i_pc = 32'h0040_0200;
        push_dump(i_pc, 32'd10);
        dump_cnt = 0;
        send_byte(8'h03);
        wait_count(50);
        i_tx_ready = 1'b0;
        d0 = o_tx_data;
        v0 = o_tx_valid;
        check_val("stall_valid", 32'(v0), 32'd1);
        repeat (5) begin
            @(negedge i_clk);
            check_val("stall_data", 32'(o_tx_data), 32'(d0));
            check_val("stall_vld", 32'(o_tx_valid), 32'(v0));
        end
        @(posedge i_clk);
        #1 i_tx_ready = 1'b1;
        wait_dump();
        check_val("stall_bytes", 32'(dump_cnt), 32'(DUMP_BYTES));

        // STEP while halted: count consumed, no enabled cycles
        push_dump(i_pc, 32'd10);
        en_cnt = 0;
        dump_cnt = 0;
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'h00);
        wait_dump();
        check_val("halted_step_en", 32'(en_cnt), 32'd0);
        check_val("halted_step_bytes", 32'(dump_cnt), 32'(DUMP_BYTES));

        // Reset in the middle of a dump, then a clean dump with a zero counter
        push_dump(i_pc, 32'd10);
        dump_cnt = 0;
        send_byte(8'h03);
        wait_count(50);
        i_rst = 1'b1;
        #1;
        check_val("midrst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_val("midrst_pipe_en", 32'(o_pipe_enable), 32'd0);
        check_val("midrst_busy", 32'(o_busy), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        @(posedge i_clk);
        #1 i_pc = 32'h0040_0300;
        push_dump(i_pc, 32'd0);
        dump_cnt = 0;
        send_byte(8'h03);
        wait_dump();
        check_val("post_rst_bytes", 32'(dump_cnt), 32'(DUMP_BYTES));
        check_val("post_rst_halted", 32'(o_halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
